// File: rtl/pool_inference_sequencer.sv
// Top-level sequencer for one classification pass and for canvas clears.
// It owns the canvas RAM port and hands it to drawing, display or pooling as needed.
//
//   state        | meaning
//   S_IDLE       | draw/display own the RAM port, waiting for a request
//   S_CLEAR      | writing zero to every canvas address
//   S_POOL_START | one-cycle start pulse to the pooling block
//   S_POOL_WAIT  | pooling block owns the RAM port, waiting for pool_done
//   S_NN_START   | one-cycle start pulse to the classifier
//   S_NN_WAIT    | waiting for nn_done, then latch the class
module pool_inference_sequencer #(
  parameter int CANVAS_SIDE    = 112,
  parameter int ADDR_WIDTH     = $clog2(CANVAS_SIDE**2),
  parameter int CLASS_WIDTH    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   classify_req,
  input  logic                   clear_req,
  input  logic                   draw_we,
  input  logic [ADDR_WIDTH-1:0]  draw_addr,
  input  logic [ADDR_WIDTH-1:0]  disp_addr,
  input  logic [ADDR_WIDTH-1:0]  pool_addr,
  input  logic                   pool_done,
  input  logic                   nn_done,
  input  logic [CLASS_WIDTH-1:0] nn_class,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_we,
  output logic                   mem_din,
  output logic                   disp_grant,
  output logic                   pool_start,
  output logic                   nn_start,
  output logic                   busy,
  output logic [CLASS_WIDTH-1:0] digit,
  output logic                   digit_valid,
  output logic                   error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CANVAS_SIDE * CANVAS_SIDE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_POOL_START, S_POOL_WAIT, S_NN_START, S_NN_WAIT
  } state_t;

  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0]  clr_cnt, clr_cnt_nxt;
  logic [TW-1:0]          tmo_cnt, tmo_cnt_nxt;
  logic [CLASS_WIDTH-1:0] digit_nxt;
  logic                   digit_valid_nxt, error_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      clr_cnt     <= '0;
      tmo_cnt     <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      error       <= 1'b0;
    end else if (en) begin
      state       <= state_nxt;
      clr_cnt     <= clr_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      digit       <= digit_nxt;
      digit_valid <= digit_valid_nxt;
      error       <= error_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    clr_cnt_nxt     = clr_cnt;
    tmo_cnt_nxt     = tmo_cnt;
    digit_nxt       = digit;
    digit_valid_nxt = digit_valid;
    error_nxt       = error;
    mem_addr        = draw_we ? draw_addr : disp_addr;
    mem_we          = draw_we;
    mem_din         = 1'b1;
    disp_grant      = ~draw_we;
    pool_start      = 1'b0;
    nn_start        = 1'b0;
    busy            = (state != S_IDLE);

    case (state)
      S_IDLE: begin
        if (clear_req) begin
          state_nxt       = S_CLEAR;
          clr_cnt_nxt     = '0;
          digit_valid_nxt = 1'b0;
          error_nxt       = 1'b0;
        end else if (classify_req) begin
          state_nxt       = S_POOL_START;
          digit_valid_nxt = 1'b0;
          error_nxt       = 1'b0;
        end
      end
      S_CLEAR: begin
        mem_addr   = clr_cnt;
        mem_we     = 1'b1;
        mem_din    = 1'b0;
        disp_grant = 1'b0;
        if (clr_cnt == LAST_ADDR) begin
          clr_cnt_nxt = '0;
          state_nxt   = S_IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
        end
      end
      S_POOL_START: begin
        mem_addr    = pool_addr;
        mem_we      = 1'b0;
        disp_grant  = 1'b0;
        pool_start  = 1'b1;
        tmo_cnt_nxt = '0;
        state_nxt   = S_POOL_WAIT;
      end
      S_POOL_WAIT: begin
        mem_addr   = pool_addr;
        mem_we     = 1'b0;
        disp_grant = 1'b0;
        // done is checked before the timeout so a late done still counts
        if (pool_done) begin
          tmo_cnt_nxt = '0;
          state_nxt   = S_NN_START;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_cnt_nxt     = '0;
          error_nxt       = 1'b1;
          digit_valid_nxt = 1'b0;
          state_nxt       = S_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      S_NN_START: begin
        nn_start    = 1'b1;
        tmo_cnt_nxt = '0;
        state_nxt   = S_NN_WAIT;
      end
      S_NN_WAIT: begin
        if (nn_done) begin
          tmo_cnt_nxt     = '0;
          digit_nxt       = nn_class;
          digit_valid_nxt = 1'b1;
          state_nxt       = S_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_cnt_nxt     = '0;
          error_nxt       = 1'b1;
          digit_valid_nxt = 1'b0;
          state_nxt       = S_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // a held start pulse reappears once en returns because the state is held too
    if (!en) begin
      mem_we     = 1'b0;
      pool_start = 1'b0;
      nn_start   = 1'b0;
    end
    if (reset) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_pool_inference_sequencer.sv
// Bench for pool_inference_sequencer: per-cycle vectors, expected outputs queued
// as each vector is driven and popped when the outputs are sampled.
module tb_pool_inference_sequencer;

  localparam int AW = 6;
  localparam int CW = 4;
  localparam int DISP = 9;
  localparam int POOL = 33;

  logic          clk = 1'b0;
  logic          reset, en, classify_req, clear_req, draw_we;
  logic [AW-1:0] draw_addr, disp_addr, pool_addr;
  logic          pool_done, nn_done;
  logic [CW-1:0] nn_class;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_din, disp_grant, pool_start, nn_start, busy;
  logic [CW-1:0] digit;
  logic          digit_valid, error;

  int n_chk = 0;
  int n_fail = 0;
  int step = 0;

  always #5 clk = ~clk;

  pool_inference_sequencer #(.CANVAS_SIDE(8), .CLASS_WIDTH(CW), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .en(en), .classify_req(classify_req), .clear_req(clear_req),
    .draw_we(draw_we), .draw_addr(draw_addr), .disp_addr(disp_addr), .pool_addr(pool_addr),
    .pool_done(pool_done), .nn_done(nn_done), .nn_class(nn_class),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .disp_grant(disp_grant),
    .pool_start(pool_start), .nn_start(nn_start), .busy(busy),
    .digit(digit), .digit_valid(digit_valid), .error(error)
  );

  typedef struct {
    logic          rst, en, cls, clr, dwe;
    logic [AW-1:0] daddr;
    logic          pd, nd;
    logic [CW-1:0] ncls;
    logic [AW-1:0] addr;
    logic          we, din, grant, ps, ns, busy;
    logic [CW-1:0] dig;
    logic          dv, er;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[15];

  function automatic vec_t v(input int rst, input int en_i, input int cls, input int clr,
                             input int dwe, input int daddr, input int pd, input int nd,
                             input int ncls, input int addr, input int we, input int din,
                             input int grant, input int ps, input int ns, input int bsy,
                             input int dig, input int dv, input int er);
    vec_t x;
    x.rst = rst[0]; x.en = en_i[0]; x.cls = cls[0]; x.clr = clr[0]; x.dwe = dwe[0];
    x.daddr = AW'(daddr); x.pd = pd[0]; x.nd = nd[0]; x.ncls = CW'(ncls);
    x.addr = AW'(addr); x.we = we[0]; x.din = din[0]; x.grant = grant[0];
    x.ps = ps[0]; x.ns = ns[0]; x.busy = bsy[0]; x.dig = CW'(dig); x.dv = dv[0]; x.er = er[0];
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %0d, expected %0d", step, nm, act, exp);
    end
  endtask

  task automatic run(input vec_t x);
    vec_t e;
    @(negedge clk);
    reset = x.rst; en = x.en; classify_req = x.cls; clear_req = x.clr;
    draw_we = x.dwe; draw_addr = x.daddr; pool_done = x.pd; nn_done = x.nd; nn_class = x.ncls;
    exp_q.push_back(x);
    #2;
    e = exp_q.pop_front();
    chk("mem_addr", 32'(mem_addr), 32'(e.addr));
    chk("mem_we", 32'(mem_we), 32'(e.we));
    chk("mem_din", 32'(mem_din), 32'(e.din));
    chk("disp_grant", 32'(disp_grant), 32'(e.grant));
    chk("pool_start", 32'(pool_start), 32'(e.ps));
    chk("nn_start", 32'(nn_start), 32'(e.ns));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("digit", 32'(digit), 32'(e.dig));
    chk("digit_valid", 32'(digit_valid), 32'(e.dv));
    chk("error", 32'(error), 32'(e.er));
    step++;
  endtask

  initial begin
    // rst en cls clr dwe daddr pd nd ncls | addr we din grant ps ns busy dig dv er
    tbl[0]  = v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 0,0,0);
    tbl[1]  = v(0,1,0,0,1,5, 0,0,0, 5,1,1,0,0,0,0,    0,0,0);
    tbl[2]  = v(0,1,1,0,0,0, 1,1,7, DISP,0,1,1,0,0,0, 0,0,0);
    tbl[3]  = v(0,1,0,0,0,0, 1,1,7, POOL,0,1,0,1,0,1, 0,0,0);
    tbl[4]  = v(0,1,0,0,0,0, 1,1,7, POOL,0,1,0,0,0,1, 0,0,0);
    tbl[5]  = v(0,1,0,0,0,0, 1,1,7, DISP,0,1,1,0,1,1, 0,0,0);
    tbl[6]  = v(0,1,0,0,0,0, 1,1,7, DISP,0,1,1,0,0,1, 0,0,0);
    tbl[7]  = v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 7,1,0);
    tbl[8]  = v(0,1,1,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 7,1,0);
    tbl[9]  = v(0,1,0,0,0,0, 0,0,0, POOL,0,1,0,1,0,1, 7,0,0);
    tbl[10] = v(0,1,0,0,1,5, 0,0,0, POOL,0,1,0,0,0,1, 7,0,0);
    tbl[11] = v(0,1,0,0,0,0, 1,0,0, POOL,0,1,0,0,0,1, 7,0,0);
    tbl[12] = v(0,1,0,0,1,5, 0,0,0, 5,1,1,0,0,1,1,    7,0,0);
    tbl[13] = v(0,1,0,0,0,0, 0,1,3, DISP,0,1,1,0,0,1, 7,0,0);
    tbl[14] = v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 3,1,0);

    disp_addr = AW'(DISP); pool_addr = AW'(POOL);
    reset = 1'b1; en = 1'b1; classify_req = 1'b0; clear_req = 1'b0; draw_we = 1'b0;
    draw_addr = '0; pool_done = 1'b0; nn_done = 1'b0; nn_class = '0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) run(tbl[i]);

    // pooling never finishes: timeout after 20 wait cycles
    run(v(0,1,1,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 3,1,0));
    run(v(0,1,0,0,0,0, 0,0,0, POOL,0,1,0,1,0,1, 3,0,0));
    for (int i = 0; i < 20; i++) run(v(0,1,0,0,0,0, 0,0,0, POOL,0,1,0,0,0,1, 3,0,0));
    // error visible; new request accepted in the same cycle clears it
    run(v(0,1,1,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 3,0,1));
    run(v(0,1,0,0,0,0, 0,0,0, POOL,0,1,0,1,0,1, 3,0,0));
    for (int i = 0; i < 19; i++) run(v(0,1,0,0,0,0, 0,0,0, POOL,0,1,0,0,0,1, 3,0,0));
    // done arrives on the last allowed wait cycle and must win over the timeout
    run(v(0,1,0,0,0,0, 1,0,0, POOL,0,1,0,0,0,1, 3,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,1,1, 3,0,0));
    run(v(0,1,0,0,0,0, 0,1,2, DISP,0,1,1,0,0,1, 3,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 2,1,0));

    // clear and classify together: clear wins; mid-clear requests and draws ignored
    run(v(0,1,1,1,0,0, 0,0,0, DISP,0,1,1,0,0,0, 2,1,0));
    for (int i = 0; i < 64; i++)
      run(v(0,1,(i == 10) ? 1 : 0,0,(i == 20) ? 1 : 0,5, 1,0,0, i,1,0,0,0,0,1, 2,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 2,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 2,0,0));

    // reset while in NN_WAIT
    run(v(0,1,1,0,0,0, 1,0,0, DISP,0,1,1,0,0,0, 2,0,0));
    run(v(0,1,0,0,0,0, 1,0,0, POOL,0,1,0,1,0,1, 2,0,0));
    run(v(0,1,0,0,0,0, 1,0,0, POOL,0,1,0,0,0,1, 2,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,1,1, 2,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,1, 2,0,0));
    run(v(1,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,1, 2,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 0,0,0));

    // en low for 3 cycles in POOL_START holds the start pulse back
    run(v(0,1,1,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 0,0,0));
    for (int i = 0; i < 3; i++) run(v(0,0,0,0,0,0, 1,0,0, POOL,0,1,0,0,0,1, 0,0,0));
    run(v(0,1,0,0,0,0, 1,0,0, POOL,0,1,0,1,0,1, 0,0,0));
    run(v(0,1,0,0,0,0, 1,0,0, POOL,0,1,0,0,0,1, 0,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,1,1, 0,0,0));
    run(v(0,1,0,0,0,0, 0,1,4, DISP,0,1,1,0,0,1, 0,0,0));
    run(v(0,1,0,0,0,0, 0,0,0, DISP,0,1,1,0,0,0, 4,1,0));
    // en low in IDLE: draw write is suppressed but the mux still follows draw_we
    run(v(0,0,0,0,1,5, 0,0,0, 5,0,1,0,0,0,0,    4,1,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_inference_sequencer.md
Name: pool_inference_sequencer

Overview:
- Top-level sequencer for one digit-classification pass.
- On a classify request it takes the canvas RAM port away from draw/display, starts the average pooling block and waits for its done, then starts the classifier and waits for its done, and finally latches the predicted class.
- It also runs a canvas clear: it writes zero to every canvas address.
- It sits between the canvas RAM, the drawing/VGA logic, the pooling block and the classifier.

Parameters:
- CANVAS_SIDE, 112, canvas side length in pixels; canvas size N = CANVAS_SIDE**2.
- ADDR_WIDTH, $clog2(CANVAS_SIDE**2), canvas address width.
- CLASS_WIDTH, 4, width of the classifier result.
- TIMEOUT_CYCLES, 65535, maximum number of cycles spent in any wait state before an error is declared.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  global enable; when 0 the FSM, counters and outputs hold their values
- classify_req  in  1  single-cycle request to classify the canvas
- clear_req  in  1  single-cycle request to clear the canvas
- draw_we  in  1  write request from the drawing logic
- draw_addr  in  ADDR_WIDTH  drawing write address
- disp_addr  in  ADDR_WIDTH  display read address
- pool_addr  in  ADDR_WIDTH  read address driven by the pooling block
- pool_done  in  1  pooling complete
- nn_done  in  1  classifier complete
- nn_class  in  CLASS_WIDTH  classifier result, valid while nn_done=1
- mem_addr  out  ADDR_WIDTH  canvas RAM address (muxed)
- mem_we  out  1  canvas RAM write enable
- mem_din  out  1  canvas RAM write data
- disp_grant  out  1  display owns the read port
- pool_start  out  1  one-cycle start pulse to the pooling block
- nn_start  out  1  one-cycle start pulse to the classifier
- busy  out  1  high in any state other than IDLE
- digit  out  CLASS_WIDTH  last latched class
- digit_valid  out  1  digit holds a valid result
- error  out  1  a timeout occurred

Behaviour:
- Reset values:
  - State is IDLE.
  - digit=0, digit_valid=0, error=0.
  - pool_start=0, nn_start=0, busy=0.
  - Clear counter and timeout counter are 0.
  - Reset applied mid-operation aborts the operation the same way, with no further RAM writes.
- States: IDLE, CLEAR, POOL_START, POOL_WAIT, NN_START, NN_WAIT. All state-decoded outputs are Moore outputs.
- IDLE:
  - mem_addr = draw_we ? draw_addr : disp_addr.
  - mem_we = draw_we, mem_din = 1.
  - disp_grant = ~draw_we.
- IDLE transitions:
  - clear_req=1 → CLEAR. Clear wins if clear_req and classify_req are high in the same cycle.
  - Otherwise classify_req=1 → POOL_START.
  - Accepting either request clears digit_valid and error on the same edge.
  - Requests arriving while busy=1 are ignored and are not queued.
- CLEAR:
  - mem_we=1, mem_din=0, mem_addr = clear counter.
  - The counter runs 0..N-1, one address per enabled cycle.
  - After address N-1 is written the counter resets to 0 and the FSM returns to IDLE. A clear takes exactly N cycles.
  - disp_grant=0; draw_we is ignored.
- POOL_START:
  - pool_start=1 for exactly one cycle, then → POOL_WAIT.
  - Throughout POOL_START and POOL_WAIT: mem_addr = pool_addr, mem_we=0, disp_grant=0, and draw writes are dropped.
- POOL_WAIT:
  - pool_done=1 → NN_START.
  - The timeout counter increments each cycle.
- NN_START:
  - nn_start=1 for one cycle, then → NN_WAIT.
  - The RAM port returns to the IDLE mux from NN_START onward.
- NN_WAIT:
  - nn_done=1 → digit ≤ nn_class, digit_valid ≤ 1, → IDLE.
- Latency: with stubs returning done immediately (pool_done already high when POOL_WAIT is entered, nn_done already high when NN_WAIT is entered), the path from classify_req to digit_valid=1 is 5 cycles:
  - edge 1 → POOL_START
  - edge 2 → POOL_WAIT
  - edge 3 → NN_START
  - edge 4 → NN_WAIT
  - edge 5 → IDLE with digit latched.
- Timeout:
  - The timeout counter resets to 0 on entry to each wait state.
  - If it reaches TIMEOUT_CYCLES without the corresponding done: error ≤ 1, digit_valid ≤ 0, → IDLE.
  - error stays set until the next request is accepted.
  - If done and timeout occur in the same cycle, done wins.
- en=0: the state, all counters, digit, digit_valid and error hold. pool_start and nn_start are forced to 0, and a pulse blocked this way is emitted once en returns to 1. The mem_addr mux still follows the current state; mem_we is forced to 0.
- done inputs are only looked at in their own wait state; stray done pulses in other states are ignored.

Test Plan:
- Reset, then a classify with immediate-done stubs (CANVAS_SIDE=8) and nn_class=7: pool_start high in cycle 1, nn_start high in cycle 3, digit=7 and digit_valid=1 in cycle 5, busy low afterwards.
- Clear with CANVAS_SIDE=8: mem_we=1 and mem_din=0 for exactly 64 cycles with mem_addr 0..63; busy falls on cycle 65; disp_grant=0 throughout.
- clear_req and classify_req in the same cycle: a CLEAR runs and pool_start is never asserted. A classify_req issued mid-clear is ignored.
- Pooling stub never asserts done, TIMEOUT_CYCLES=20: error=1 and digit_valid=0 after 20 wait cycles, FSM back in IDLE. A following successful classify clears error.
- Arbitration during POOL_WAIT: draw_we=1 gives mem_we=0 and mem_addr=pool_addr; in IDLE, draw_we=1 with draw_addr=5 gives mem_addr=5, mem_we=1, disp_grant=0.
- Reset asserted in NN_WAIT and en=0 held for 3 cycles in POOL_START:
  - After the reset, all outputs take their reset values and the FSM is in IDLE.
  - With en held low, pool_start stays 0 and the FSM stays in POOL_START; pool_start pulses once when en returns to 1.
